// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and the data memory.
//
// Accepts one memory op at a time from execute (effective address from the
// ALU, rs2 store data, funct3 width code, rd), runs a single outstanding
// request/grant/response transaction on the data-memory port, and returns
// aligned, sign/zero-extended load data for writeback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_valid/ex_ready   op handshake from execute (ready only when idle)
//   ex_load, ex_store   op kind (load wins if both are set)
//   ex_funct3           RV32I width code
//   ex_addr, ex_wdata   effective address, store data
//   ex_rd               load destination register
//   dmem_*              request/grant/response data-memory port
//   wb_valid/rd/data    load writeback (one-cycle valid, data held)
//   err_misaligned      pulse: misaligned address or illegal funct3
//   err_timeout         pulse: transaction aborted waiting on memory
//   busy                transaction in flight (pipeline stall)
//
// Parameter:
//   TIMEOUT_CYCLES      cycles allowed in REQ or WAIT before abort; 0 = never
// -----------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // Last counter value before abort; only meaningful when the timeout is enabled.
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [4:0]  rd_reg, rd_next;
  logic        load_reg, load_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        wb_valid_reg, wb_valid_next;
  logic [4:0]  wb_rd_reg, wb_rd_next;
  logic [31:0] wb_data_reg, wb_data_next;
  logic        err_mis_reg, err_mis_next;
  logic        err_to_reg, err_to_next;

  logic        accept;
  logic        illegal;
  logic        timed_out;
  logic        in_req;
  logic [1:0]  off;
  logic [3:0]  be_lane;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  assign accept    = ex_valid && (state_reg == IDLE) && (ex_load || ex_store);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);

  // Legality of the op presented at accept; load takes priority over store.
  always_comb begin
    illegal = 1'b0;
    if (ex_load) begin
      illegal = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    end else begin
      illegal = ex_funct3[2] || (ex_funct3 == 3'b011);
    end
    if ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) begin
      illegal = 1'b1;
    end
    if ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
  end

  // Lane steering for the latched op. funct3[1:0] is the access size for
  // both loads and stores (the unsigned-load bit does not affect lanes).
  assign off = addr_reg[1:0];

  always_comb begin
    be_lane   = 4'b1111;
    wdata_rep = wdata_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        be_lane   = 4'b0001 << off;
        wdata_rep = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be_lane   = 4'b0011 << off;
        wdata_rep = {2{wdata_reg[15:0]}};
      end
      default: begin
        be_lane   = 4'b1111;
        wdata_rep = wdata_reg;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  assign rdata_shift = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = dmem_rdata;
    case (funct3_reg)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
      3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    funct3_next   = funct3_reg;
    rd_next       = rd_reg;
    load_next     = load_reg;
    cnt_next      = cnt_reg + 32'd1;
    wb_valid_next = 1'b0;
    wb_rd_next    = wb_rd_reg;
    wb_data_next  = wb_data_reg;
    err_mis_next  = 1'b0;
    err_to_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Holding the counter at zero here clears it on entry to REQ.
        cnt_next = 32'd0;
        if (accept) begin
          if (illegal) begin
            err_mis_next = 1'b1;
          end else begin
            addr_next   = ex_addr;
            wdata_next  = ex_wdata;
            funct3_next = ex_funct3;
            rd_next     = ex_rd;
            load_next   = ex_load;
            state_next  = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          cnt_next   = 32'd0;
          state_next = load_reg ? WAIT : IDLE;
        end else if (timed_out) begin
          err_to_next = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          wb_valid_next = 1'b1;
          wb_rd_next    = rd_reg;
          wb_data_next  = load_ext;
          state_next    = IDLE;
        end else if (timed_out) begin
          err_to_next = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      funct3_reg   <= 3'd0;
      rd_reg       <= 5'd0;
      load_reg     <= 1'b0;
      cnt_reg      <= 32'd0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_data_reg  <= 32'd0;
      err_mis_reg  <= 1'b0;
      err_to_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      funct3_reg   <= funct3_next;
      rd_reg       <= rd_next;
      load_reg     <= load_next;
      cnt_reg      <= cnt_next;
      wb_valid_reg <= wb_valid_next;
      wb_rd_reg    <= wb_rd_next;
      wb_data_reg  <= wb_data_next;
      err_mis_reg  <= err_mis_next;
      err_to_reg   <= err_to_next;
    end
  end

  // Request fields are decoded from the latched op and gated by the REQ
  // state, so they are stable for the whole request and zero otherwise.
  assign in_req     = (state_reg == REQ);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req && !load_reg;
  assign dmem_addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign dmem_be    = in_req ? be_lane : 4'd0;
  assign dmem_wdata = (in_req && !load_reg) ? wdata_rep : 32'd0;

  assign ex_ready       = (state_reg == IDLE);
  assign busy           = (state_reg != IDLE);
  assign wb_valid       = wb_valid_reg;
  assign wb_rd          = wb_rd_reg;
  assign wb_data        = wb_data_reg;
  assign err_misaligned = err_mis_reg;
  assign err_timeout    = err_to_reg;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit sitting directly downstream of the ALU in the execute/memory boundary. Takes the ALU result as the effective address, plus rs2 store data and funct3. It runs a single outstanding request/grant/response transaction on the data-memory port. Loaded data is aligned and sign/zero-extended, and the writeback result is presented for rd.

Parameters:
TIMEOUT_CYCLES, 255, consecutive cycles allowed in REQ or WAIT before abort; 0 disables timeout

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
ex_valid  input  1  memory op presented by execute stage
ex_ready  output  1  LSU can accept (high only in IDLE)
ex_load  input  1  op is a load (priority over ex_store if both high)
ex_store  input  1  op is a store
ex_funct3  input  3  RV32I width: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
ex_addr  input  32  effective address (ALU ADD output)
ex_wdata  input  32  store data (rs2)
ex_rd  input  5  load destination register
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, {ex_addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data word
wb_valid  output  1  one-cycle pulse, load result ready
wb_rd  output  5  destination register
wb_data  output  32  extended load result
err_misaligned  output  1  one-cycle pulse: misaligned or illegal funct3
err_timeout  output  1  one-cycle pulse: transaction aborted
busy  output  1  state != IDLE (pipeline stall)

Behaviour:
- States: IDLE, REQ, WAIT. Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, err_* all 0. ex_ready=1 and busy=0 from the first cycle after reset.
- Accept: ex_valid && ex_ready && (ex_load||ex_store). Latch addr, funct3, wdata, rd, load/store. ex_valid with neither load nor store is a no-op.
- Error check at accept:
  - LH/LHU/SH with addr[0]=1 is illegal.
  - LW/SW with addr[1:0]!=0 is illegal.
  - Load funct3 011/110/111 and store funct3 1xx/011 are illegal.
  - On error: err_misaligned=1 next cycle, no dmem request, no wb, stay IDLE.
- REQ: dmem_req=1; addr/we/be/wdata held stable until the cycle dmem_gnt=1 is sampled.
  - On gnt, a store goes to IDLE (no wb).
  - On gnt, a load goes to WAIT; dmem_req drops in the same transition.
- WAIT: dmem_rvalid is sampled only in WAIT; the memory guarantees rvalid at least 1 cycle after gnt. On rvalid, next cycle: wb_valid=1, wb_rd, wb_data valid, state IDLE. wb_data/wb_rd hold until the next load completes.
- Minimum latency with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - Load: accept at T, REQ at T+1, WAIT at T+2, wb_valid at T+3, ex_ready again at T+3.
  - Store: accept at T, REQ at T+1, ex_ready again at T+2.
- Byte enables (off = addr[1:0]): SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extract: byte = rdata[8*off+:8]; half = rdata[8*off+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
- Timeout: the counter clears on entry to REQ and on entry to WAIT, and increments each cycle in that state. When it reaches TIMEOUT_CYCLES without gnt/rvalid:
  - err_timeout=1 next cycle.
  - State goes to IDLE; dmem_req drops.
  - No wb.
- Reset mid-transaction: abandon the transaction; dmem_req=0 the cycle after reset is sampled. A late rvalid in IDLE is ignored and produces no wb.
- Any rvalid or gnt in IDLE is ignored.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_req at T+1, we=1, addr=0x100, be=1111, wdata=0xDEADBEEF; ex_ready at T+2; no wb_valid.
- LB addr=0x203, rd=5, rdata=0x80FF1234 -> be=1000, addr=0x200; wb_valid at T+3; wb_rd=5, wb_data=0xFFFFFF80. LBU on the same inputs -> 0x00000080.
- SH addr=0x102, wdata=0x0000ABCD -> be=1100, wdata=0xABCDABCD. LHU addr=0x102, rdata=0x9876_5432 -> wb_data=0x00009876.
- LW addr=0x101 -> err_misaligned pulses 1 cycle; dmem_req stays 0; wb_valid stays 0; ex_ready stays 1.
- Load with gnt held low 3 cycles, then rvalid delayed 2 cycles -> request fields stable throughout REQ; busy=1; wb_valid exactly once.
- TIMEOUT_CYCLES=4, no rvalid -> err_timeout after 4 WAIT cycles, IDLE next. Separately, rst asserted in WAIT followed by a late rvalid -> no wb_valid; all outputs at reset values.
